// File: rtl/rot_coef_sequencer.sv
// Sequences one rotation-coefficient pass: restart the datapath, let it settle,
// sweep the 8 coefficient selects and stream each captured value downstream.
module rot_coef_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 24,
  parameter int unsigned SEL_WAIT      = 2,
  parameter int unsigned W             = 33
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          angle,
  output logic                busy,
  output logic                done,
  output logic                mp_reset,
  output logic [2:0]          mp_aci,
  output logic [2:0]          mp_selection,
  input  logic signed [W-1:0] mp_value,
  output logic                coef_valid,
  input  logic                coef_ready,
  output logic [2:0]          coef_idx,
  output logic signed [W-1:0] coef_data
);

  localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned WCW = (SEL_WAIT > 1) ? $clog2(SEL_WAIT) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [WCW-1:0] SEL_LAST    = WCW'(SEL_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_DP,
    S_SETTLE,
    S_SEL,
    S_STREAM,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          k_q, k_d;
  logic [2:0]          aci_q, aci_d;
  logic [2:0]          sel_q, sel_d;
  logic [2:0]          idx_q, idx_d;
  logic signed [W-1:0] data_q, data_d;
  logic [SCW-1:0]      scnt_q, scnt_d;
  logic [WCW-1:0]      wcnt_q, wcnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      aci_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      scnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      aci_q   <= aci_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      scnt_q  <= scnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Counters default to zero so each one clears on entry to its state.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    aci_d   = aci_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    data_d  = data_q;
    scnt_d  = '0;
    wcnt_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          aci_d   = angle;
          k_d     = '0;
          state_d = S_RST_DP;
        end
      end
      S_RST_DP: state_d = S_SETTLE;
      S_SETTLE: begin
        if (scnt_q == SETTLE_LAST) begin
          sel_d   = k_q;
          state_d = S_SEL;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      S_SEL: begin
        if (wcnt_q == SEL_LAST) begin
          data_d  = mp_value;
          idx_d   = k_q;
          state_d = S_STREAM;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (coef_ready) begin
          if (k_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 3'd1;
            sel_d   = k_q + 3'd1;
            state_d = S_SEL;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    coef_valid   = (state_q == S_STREAM);
    mp_reset     = reset | (state_q == S_RST_DP);
    mp_aci       = aci_q;
    mp_selection = sel_q;
    coef_idx     = idx_q;
    coef_data    = data_q;
  end

endmodule

// File: tb/tb_rot_coef_sequencer.sv
// Self-checking bench for rot_coef_sequencer: timing-rule reference model plus
// directed scenarios, random traffic and a short-parameter second instance.
module tb_rot_coef_sequencer;

  localparam int SC = 24;
  localparam int SW = 2;
  localparam int T0 = 2 + SC + SW;
  localparam int TD = T0 + 7 * (SW + 1) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, start, coef_ready;
  logic [2:0]         angle;
  logic               busy, done, mp_reset, coef_valid;
  logic [2:0]         mp_aci, mp_selection, coef_idx;
  logic signed [32:0] mp_value, coef_data;
  logic signed [32:0] dp_base;

  assign mp_value = dp_base + {30'b0, mp_selection};

  rot_coef_sequencer #(.SETTLE_CYCLES(SC), .SEL_WAIT(SW), .W(33)) dut (
    .clk(clk), .reset(reset), .start(start), .angle(angle),
    .busy(busy), .done(done), .mp_reset(mp_reset), .mp_aci(mp_aci),
    .mp_selection(mp_selection), .mp_value(mp_value),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_idx(coef_idx), .coef_data(coef_data)
  );

  logic               reset2, start2;
  logic               busy2, done2, mp_reset2, coef_valid2;
  logic [2:0]         mp_aci2, mp_selection2, coef_idx2;
  logic signed [32:0] mp_value2, coef_data2;

  assign mp_value2 = 33'sd1000 + {30'b0, mp_selection2};

  rot_coef_sequencer #(.SETTLE_CYCLES(1), .SEL_WAIT(1), .W(33)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .angle(3'd1),
    .busy(busy2), .done(done2), .mp_reset(mp_reset2), .mp_aci(mp_aci2),
    .mp_selection(mp_selection2), .mp_value(mp_value2),
    .coef_valid(coef_valid2), .coef_ready(1'b1),
    .coef_idx(coef_idx2), .coef_data(coef_data2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s at cycle %0d: timed out waiting for DUT", name, cyc);
  endtask

  // Reference model: pass progress is the cycle offset from the accepted start,
  // minus the number of stalled stream cycles.
  bit                 chk_en = 0;
  bit                 m_active = 0;
  int                 m_s = 0, m_stall = 0;
  logic [2:0]         m_aci = '0, m_sel = '0, m_idx = '0;
  logic signed [32:0] m_data = '0;
  bit                 seen_valid = 0;
  int                 rec_first = -1, rec_done = -1, n_done = 0;

  always @(negedge clk) begin
    int d, j;
    bit ev, edone, erst;
    d = 0; ev = 0; edone = 0;
    if (m_active) begin
      d = cyc - m_s - m_stall;
      j = d - (2 + SC);
      if (j >= 0 && j < 8 * (SW + 1)) begin
        m_sel = 3'(j / (SW + 1));
        if ((j % (SW + 1)) == SW) begin
          ev     = 1;
          m_idx  = 3'(j / (SW + 1));
          m_data = dp_base + {30'b0, m_idx};
        end
      end
      edone = (d == TD);
    end
    erst = reset || (m_active && d == 1);
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_active));
      check("done", 64'(done), 64'(edone));
      check("coef_valid", 64'(coef_valid), 64'(ev));
      check("mp_reset", 64'(mp_reset), 64'(erst));
      check("mp_aci", 64'(mp_aci), 64'(m_aci));
      check("mp_selection", 64'(mp_selection), 64'(m_sel));
      check("coef_idx", 64'(coef_idx), 64'(m_idx));
      check("coef_data", 64'(coef_data), 64'(m_data));
    end
    if (m_active && coef_valid && !seen_valid) begin
      seen_valid = 1;
      rec_first  = cyc - m_s;
    end
    if (m_active && done) begin
      rec_done = cyc - m_s;
      n_done++;
    end
    if (reset) begin
      m_active = 0; m_aci = '0; m_sel = '0; m_idx = '0; m_data = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_s = cyc; m_stall = 0; m_aci = angle; seen_valid = 0;
      end
    end else begin
      if (ev && !coef_ready) m_stall++;
      if (edone) m_active = 0;
    end
  end

  task automatic cycle_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [2:0] a);
    start = 1'b1;
    angle = a;
    cycle_wait(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while ((m_active || busy) && i < budget) begin
      cycle_wait(1);
      i++;
    end
    if (i >= budget) timeout("wait_idle");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    reset = 1'b1; start = 1'b0; angle = '0; coef_ready = 1'b1; dp_base = 33'sd1000;
    reset2 = 1'b1; start2 = 1'b0;
    cycle_wait(3);
    chk_en = 1; reset = 1'b0; reset2 = 1'b0;
    check("rst_coef_data", 64'(coef_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // Nominal pass, ready tied high
    n_done = 0;
    pulse_start(3'd3);
    wait_idle(200);
    check("p1_first_valid_cycle", 64'(rec_first), 64'(28));
    check("p1_done_cycle", 64'(rec_done), 64'(50));
    check("p1_last_data", 64'(coef_data), 64'(1007));
    check("p1_last_idx", 64'(coef_idx), 64'(7));
    check("p1_sel_hold", 64'(mp_selection), 64'(7));
    check("p1_done_count", 64'(n_done), 64'(1));

    // Backpressure on idx 2 for 5 cycles
    pulse_start(3'd3);
    i = 0;
    while (!(coef_valid && coef_idx == 3'd2) && i < 100) begin
      cycle_wait(1);
      i++;
    end
    if (i >= 100) timeout("p2_wait_idx2");
    coef_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check("p2_stall_valid", 64'(coef_valid), 64'(1));
      check("p2_stall_idx", 64'(coef_idx), 64'(2));
      check("p2_stall_data", 64'(coef_data), 64'(1002));
      cycle_wait(1);
    end
    coef_ready = 1'b1;
    wait_idle(200);
    check("p2_done_cycle", 64'(rec_done), 64'(55));

    // Start pulses in SETTLE, STREAM and DONE are ignored
    n_done = 0;
    pulse_start(3'd3);
    cycle_wait(9);
    pulse_start(3'd6);
    cycle_wait(20);
    check("p3_in_stream", 64'(coef_valid), 64'(1));
    pulse_start(3'd6);
    cycle_wait(18);
    check("p3_done_now", 64'(done), 64'(1));
    pulse_start(3'd6);
    check("p3_idle_after", 64'(busy), 64'(0));
    check("p3_aci_kept", 64'(mp_aci), 64'(3));
    wait_idle(200);
    check("p3_done_count", 64'(n_done), 64'(1));

    // Reset mid-pass, then a fresh full pass
    pulse_start(3'd3);
    cycle_wait(34);
    reset = 1'b1;
    #1;
    check("p4_mp_reset_in_reset", 64'(mp_reset), 64'(1));
    cycle_wait(1);
    reset = 1'b0;
    check("p4_valid_cleared", 64'(coef_valid), 64'(0));
    check("p4_busy_cleared", 64'(busy), 64'(0));
    check("p4_aci_cleared", 64'(mp_aci), 64'(0));
    check("p4_sel_cleared", 64'(mp_selection), 64'(0));
    n_done = 0;
    pulse_start(3'd2);
    wait_idle(200);
    check("p4_fresh_done_count", 64'(n_done), 64'(1));
    check("p4_fresh_done_cycle", 64'(rec_done), 64'(50));

    // Back-to-back passes
    pulse_start(3'd3);
    wait_idle(200);
    pulse_start(3'd5);
    check("p5_rst_dp", 64'(mp_reset), 64'(1));
    check("p5_aci", 64'(mp_aci), 64'(5));
    check("p5_busy", 64'(busy), 64'(1));
    wait_idle(200);
    check("p5_first_valid_cycle", 64'(rec_first), 64'(28));

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      coef_ready = ($urandom % 10) < 7;
      start      = ($urandom % 8) == 0;
      angle      = 3'($urandom);
      reset      = ($urandom % 400) == 0;
      if (!m_active && !busy && ($urandom % 4) == 0)
        dp_base = 33'({$urandom, $urandom});
      cycle_wait(1);
    end
    reset = 1'b0; start = 1'b0; coef_ready = 1'b1;
    cycle_wait(1);
    wait_idle(400);

    // Short-parameter instance: SETTLE_CYCLES=1, SEL_WAIT=1
    start2 = 1'b1;
    cycle_wait(1);
    start2 = 1'b0;
    for (int r = 1; r <= 20; r++) begin
      bit ev2;
      ev2 = (r >= 4) && (r <= 18) && (((r - 4) % 2) == 0);
      check("s_valid", 64'(coef_valid2), 64'(ev2));
      if (ev2) begin
        check("s_idx", 64'(coef_idx2), 64'((r - 4) / 2));
        check("s_data", 64'(coef_data2), 64'(1000 + (r - 4) / 2));
      end
      check("s_done", 64'(done2), 64'(r == 19));
      check("s_busy", 64'(busy2), 64'(r <= 19));
      check("s_mp_reset", 64'(mp_reset2), 64'(r == 1));
      cycle_wait(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
